// File: rtl/cam_cfg_pkg.sv
// Shared types and entry-field layout for the camera register-initialisation sequencer.
package cam_cfg_pkg;

    localparam int ENTRY_W  = 25;
    localparam int RD_BIT   = 24;
    localparam int REG_MSB  = 23;
    localparam int REG_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int GAP_CYC  = 4;
    localparam logic [15:0] DELAY_MARK = 16'hFFFF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_LOAD,
        S_DELAY,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_CHECK,
        S_GAP,
        S_NEXT,
        S_DONE,
        S_FAIL
    } state_t;

    // A write to the marker address is a pure wait, never bus traffic.
    function automatic logic is_delay(input logic [ENTRY_W-1:0] e);
        return !e[RD_BIT] && (e[REG_MSB:REG_LSB] == DELAY_MARK);
    endfunction

endpackage

// File: rtl/cam_cfg_rom.sv
// Sensor init table: index -> {rd, reg[15:0], data[7:0]}.
module cam_cfg_rom
    import cam_cfg_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic [IDX_W-1:0]   index,
    output logic [ENTRY_W-1:0] entry
);

    // Unlisted slots are zero-length delays so the walk stays harmless.
    always_comb begin
        entry = {1'b0, DELAY_MARK, 8'h00};
        case (32'(index))
            0:  entry = {1'b1, 16'h300A, 8'h56};
            1:  entry = {1'b1, 16'h300B, 8'h40};
            2:  entry = {1'b0, 16'h3008, 8'h82};
            3:  entry = {1'b0, 16'hFFFF, 8'h02};
            4:  entry = {1'b0, 16'h3008, 8'h42};
            5:  entry = {1'b0, 16'h3103, 8'h03};
            6:  entry = {1'b0, 16'h3017, 8'hFF};
            7:  entry = {1'b0, 16'h3018, 8'hFF};
            8:  entry = {1'b0, 16'h3034, 8'h1A};
            9:  entry = {1'b0, 16'h3037, 8'h13};
            10: entry = {1'b0, 16'h3108, 8'h01};
            11: entry = {1'b0, 16'h3630, 8'h36};
            12: entry = {1'b0, 16'h3631, 8'h0E};
            13: entry = {1'b0, 16'h3632, 8'hE2};
            14: entry = {1'b0, 16'h3633, 8'h12};
            15: entry = {1'b0, 16'h3621, 8'hE0};
            16: entry = {1'b0, 16'h3704, 8'hA0};
            17: entry = {1'b0, 16'h3703, 8'h5A};
            18: entry = {1'b0, 16'h3715, 8'h78};
            19: entry = {1'b0, 16'h3717, 8'h01};
            20: entry = {1'b0, 16'h370B, 8'h60};
            21: entry = {1'b0, 16'h3705, 8'h1A};
            22: entry = {1'b0, 16'h3905, 8'h02};
            23: entry = {1'b0, 16'h3906, 8'h10};
            24: entry = {1'b0, 16'h3901, 8'h0A};
            25: entry = {1'b0, 16'h3731, 8'h12};
            26: entry = {1'b0, 16'h3600, 8'h08};
            27: entry = {1'b0, 16'h3601, 8'h33};
            28: entry = {1'b0, 16'h4300, 8'h61};
            29: entry = {1'b0, 16'h501F, 8'h01};
            30: entry = {1'b0, 16'h3820, 8'h46};
            31: entry = {1'b0, 16'h3821, 8'h01};
            default: entry = {1'b0, DELAY_MARK, 8'h00};
        endcase
    end

endmodule

// File: rtl/cam_cfg_seq.sv
// Walks the init table through the I2C byte driver, verifying reads and retrying failed attempts.
module cam_cfg_seq
    import cam_cfg_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR     = 8'h78,
    parameter int         REG_NUM      = 64,
    parameter int         PWR_WAIT_CYC = 16000,
    parameter int         DELAY_UNIT   = 800,
    parameter int         RETRY_MAX    = 3,
    parameter int         BUSY_TO      = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       cfg_start,
    input  logic                       i2c_busy,
    input  logic                       i2c_err,
    input  logic [7:0]                 i2c_rd_data,
    output logic                       i2c_start_en,
    output logic                       i2c_wr_rd_flag,
    output logic [7:0]                 i2c_device_addr,
    output logic [15:0]                i2c_register,
    output logic [7:0]                 i2c_data_byte,
    output logic                       cfg_busy,
    output logic                       cfg_done,
    output logic                       cfg_fail,
    output logic [$clog2(REG_NUM)-1:0] cfg_index
);

    localparam int IDX_W   = $clog2(REG_NUM);
    localparam int DLY_MAX = 255 * DELAY_UNIT;
    localparam int TMR_M1  = (PWR_WAIT_CYC > DLY_MAX) ? PWR_WAIT_CYC : DLY_MAX;
    localparam int TMR_M2  = (TMR_M1 > BUSY_TO) ? TMR_M1 : BUSY_TO;
    localparam int TMR_MAX = (TMR_M2 > GAP_CYC) ? TMR_M2 : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RTY_W   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    state_t               state;
    logic [TMR_W-1:0]     timer;
    logic [RTY_W-1:0]     retry;
    logic [ENTRY_W-1:0]   entry;
    logic [7:0]           rd_cap;
    logic                 timed_out;
    logic                 attempt_ok;

    cam_cfg_rom #(.IDX_W(IDX_W)) u_rom (
        .index (cfg_index),
        .entry (entry)
    );

    assign i2c_device_addr = DEV_ADDR;
    assign attempt_ok = !timed_out && !i2c_err &&
                        (!i2c_wr_rd_flag || (rd_cap == i2c_data_byte));

    // The driver clears its read byte as busy falls, so only bytes seen while busy count.
    always_ff @(posedge clk_i) begin
        if (i2c_busy) rd_cap <= i2c_rd_data;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            timer          <= '0;
            retry          <= '0;
            timed_out      <= 1'b0;
            i2c_start_en   <= 1'b0;
            i2c_wr_rd_flag <= 1'b0;
            i2c_register   <= '0;
            i2c_data_byte  <= '0;
            cfg_busy       <= 1'b0;
            cfg_done       <= 1'b0;
            cfg_fail       <= 1'b0;
            cfg_index      <= '0;
        end else begin
            i2c_start_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (cfg_start) begin
                        state     <= S_PWR_WAIT;
                        timer     <= TMR_W'(PWR_WAIT_CYC - 1);
                        cfg_busy  <= 1'b1;
                        cfg_done  <= 1'b0;
                        cfg_fail  <= 1'b0;
                        cfg_index <= '0;
                        retry     <= '0;
                    end
                end
                S_PWR_WAIT: begin
                    if (timer == '0) state <= S_LOAD;
                    else             timer <= timer - TMR_W'(1);
                end
                S_LOAD: begin
                    if (is_delay(entry)) begin
                        state <= S_DELAY;
                        timer <= TMR_W'(entry[DATA_MSB:0]) * TMR_W'(DELAY_UNIT);
                    end else begin
                        i2c_wr_rd_flag <= entry[RD_BIT];
                        i2c_register   <= entry[REG_MSB:REG_LSB];
                        i2c_data_byte  <= entry[DATA_MSB:0];
                        i2c_start_en   <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state     <= S_WAIT_HI;
                    timer     <= TMR_W'(BUSY_TO - 1);
                    timed_out <= 1'b0;
                end
                S_WAIT_HI: begin
                    if (i2c_busy) begin
                        state <= S_WAIT_LO;
                    end else if (timer == '0) begin
                        state     <= S_CHECK;
                        timed_out <= 1'b1;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (!i2c_busy) state <= S_CHECK;
                end
                S_CHECK: begin
                    if (attempt_ok) begin
                        state <= S_NEXT;
                    end else if (retry < RTY_W'(RETRY_MAX)) begin
                        retry <= retry + RTY_W'(1);
                        timer <= TMR_W'(GAP_CYC - 1);
                        state <= S_GAP;
                    end else begin
                        state    <= S_FAIL;
                        cfg_fail <= 1'b1;
                        cfg_busy <= 1'b0;
                    end
                end
                // Idle long enough for the driver's STOP to finish before restarting.
                S_GAP: begin
                    if (timer == '0) begin
                        i2c_start_en <= 1'b1;
                        state        <= S_ISSUE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                S_DELAY: begin
                    if (timer == '0) state <= S_NEXT;
                    else             timer <= timer - TMR_W'(1);
                end
                S_NEXT: begin
                    retry <= '0;
                    if (cfg_index == IDX_W'(REG_NUM - 1)) begin
                        state    <= S_DONE;
                        cfg_done <= 1'b1;
                        cfg_busy <= 1'b0;
                    end else begin
                        cfg_index <= cfg_index + IDX_W'(1);
                        state     <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_cfg_seq.sv
// Scoreboard bench for cam_cfg_seq with a behavioural I2C driver model.
module tb_cam_cfg_seq;

    localparam int REG_NUM      = 8;
    localparam int PWR_WAIT_CYC = 20;
    localparam int DELAY_UNIT   = 800;
    localparam int RETRY_MAX    = 3;
    localparam int BUSY_TO      = 16;
    localparam int IDX_W        = $clog2(REG_NUM);

    logic             clk_i = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_start = 1'b0;
    logic             i2c_busy = 1'b0;
    logic             i2c_err = 1'b0;
    logic [7:0]       i2c_rd_data = 8'h00;
    logic             i2c_start_en;
    logic             i2c_wr_rd_flag;
    logic [7:0]       i2c_device_addr;
    logic [15:0]      i2c_register;
    logic [7:0]       i2c_data_byte;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_fail;
    logic [IDX_W-1:0] cfg_index;

    always #5 clk_i = ~clk_i;

    cam_cfg_seq #(
        .DEV_ADDR     (8'h78),
        .REG_NUM      (REG_NUM),
        .PWR_WAIT_CYC (PWR_WAIT_CYC),
        .DELAY_UNIT   (DELAY_UNIT),
        .RETRY_MAX    (RETRY_MAX),
        .BUSY_TO      (BUSY_TO)
    ) dut (
        .clk_i           (clk_i),
        .rst_n           (rst_n),
        .cfg_start       (cfg_start),
        .i2c_busy        (i2c_busy),
        .i2c_err         (i2c_err),
        .i2c_rd_data     (i2c_rd_data),
        .i2c_start_en    (i2c_start_en),
        .i2c_wr_rd_flag  (i2c_wr_rd_flag),
        .i2c_device_addr (i2c_device_addr),
        .i2c_register    (i2c_register),
        .i2c_data_byte   (i2c_data_byte),
        .cfg_busy        (cfg_busy),
        .cfg_done        (cfg_done),
        .cfg_fail        (cfg_fail),
        .cfg_index       (cfg_index)
    );

    // kind: 0 = start_en pulse, 1 = done, 2 = fail
    typedef struct {
        int          kind;
        logic [15:0] regv;
        logic [7:0]  data;
        logic        rd;
        int          idx;
        int          min_gap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int         fail_idx = -1;
    bit         no_busy = 1'b0;
    bit         bad_id = 1'b0;
    int         left = 0;
    logic [7:0] resp = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic exp_pulse(input logic [15:0] r, input logic [7:0] d, input logic rd, input int mg);
        sb.push_back('{0, r, d, rd, 0, mg});
    endtask

    task automatic exp_end(input int kind, input int idx);
        sb.push_back('{kind, 16'h0, 8'h0, 1'b0, idx, 0});
    endtask

    task automatic exp_head();
        exp_pulse(16'h300A, 8'h56, 1'b1, PWR_WAIT_CYC);
        exp_pulse(16'h300B, 8'h40, 1'b1, 0);
        exp_pulse(16'h3008, 8'h82, 1'b0, 0);
        exp_pulse(16'h3008, 8'h42, 1'b0, 2 * DELAY_UNIT);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_start_en"}, 32'(i2c_start_en), 0);
        chk({tag, "_wr_rd"},    32'(i2c_wr_rd_flag), 0);
        chk({tag, "_dev_addr"}, 32'(i2c_device_addr), 32'h78);
        chk({tag, "_register"}, 32'(i2c_register), 0);
        chk({tag, "_data"},     32'(i2c_data_byte), 0);
        chk({tag, "_busy"},     32'(cfg_busy), 0);
        chk({tag, "_done"},     32'(cfg_done), 0);
        chk({tag, "_fail"},     32'(cfg_fail), 0);
        chk({tag, "_index"},    32'(cfg_index), 0);
    endtask

    task automatic start_and_wait(input string tag, input int budget, input int poke_at);
        @(negedge clk_i);
        cfg_start = 1'b1;
        @(negedge clk_i);
        cfg_start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(cfg_busy), 1);
        for (int i = 0; i < budget; i++) begin
            if (cfg_done || cfg_fail) break;
            if (i == poke_at) begin
                cfg_start = 1'b1;
                @(negedge clk_i);
                cfg_start = 1'b0;
            end
            @(negedge clk_i);
        end
        checks++;
        if (!(cfg_done || cfg_fail)) begin
            errors++;
            $display("FAIL %s_end_timeout actual=no_end required=done_or_fail", tag);
        end
        repeat (2) @(negedge clk_i);
        chk({tag, "_sb_drained"}, 32'(sb.size()), 0);
        sb.delete();
    endtask

    // Driver model: busy for 6 cycles, read byte valid only on the last busy cycle.
    initial forever begin
        @(negedge clk_i);
        if (!rst_n) begin
            i2c_busy = 1'b0;
            i2c_err = 1'b0;
            i2c_rd_data = 8'h00;
            left = 0;
        end else if (left > 0) begin
            left--;
            if (left == 1) i2c_rd_data = resp;
            if (left == 0) begin
                i2c_busy = 1'b0;
                i2c_rd_data = 8'hFF;
            end
        end else if (i2c_start_en && !no_busy) begin
            i2c_busy = 1'b1;
            i2c_rd_data = 8'h00;
            left = 6;
            i2c_err = (int'(cfg_index) == fail_idx);
            if (i2c_register == 16'h300A)      resp = 8'h56;
            else if (i2c_register == 16'h300B) resp = bad_id ? 8'h41 : 8'h40;
            else                               resp = 8'h00;
        end
    end

    // Monitor: pops the scoreboard on every start pulse and every done/fail rise.
    initial begin
        exp_t e;
        int   gap;
        logic busy_q, done_q, fail_q;
        gap = 0;
        busy_q = 1'b0;
        done_q = 1'b0;
        fail_q = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (cfg_start && !busy_q) begin
                gap = 0;
            end else if (i2c_start_en) begin
                chk("start_while_busy", 32'(i2c_busy), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start actual=reg_%0h required=no_pulse", i2c_register);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", 32'(e.kind), 0);
                    chk("pulse_reg",  32'(i2c_register), 32'(e.regv));
                    chk("pulse_data", 32'(i2c_data_byte), 32'(e.data));
                    chk("pulse_rd",   32'(i2c_wr_rd_flag), 32'(e.rd));
                    checks++;
                    if (gap < e.min_gap) begin
                        errors++;
                        $display("FAIL pulse_gap actual=%0d required_min=%0d", gap, e.min_gap);
                    end
                end
                gap = 0;
            end else begin
                gap++;
            end
            if ((cfg_done && !done_q) || (cfg_fail && !fail_q)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_end actual=done%0d_fail%0d required=none", cfg_done, cfg_fail);
                end else begin
                    e = sb.pop_front();
                    chk("end_kind",  32'(cfg_done ? 1 : 2), 32'(e.kind));
                    chk("end_index", 32'(cfg_index), 32'(e.idx));
                    chk("end_busy",  32'(cfg_busy), 0);
                end
            end
            busy_q = cfg_busy;
            done_q = cfg_done;
            fail_q = cfg_fail;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        chk_reset("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);

        // Full pass; a stray cfg_start mid-run must be ignored.
        exp_head();
        exp_pulse(16'h3103, 8'h03, 1'b0, 0);
        exp_pulse(16'h3017, 8'hFF, 1'b0, 0);
        exp_pulse(16'h3018, 8'hFF, 1'b0, 0);
        exp_end(1, REG_NUM - 1);
        start_and_wait("run_ok", 4000, 100);
        chk("run_ok_done", 32'(cfg_done), 1);

        // NACK on every attempt of entry 5: four pulses, then fail at index 5.
        fail_idx = 5;
        exp_head();
        exp_pulse(16'h3103, 8'h03, 1'b0, 0);
        for (int i = 0; i < RETRY_MAX; i++) exp_pulse(16'h3103, 8'h03, 1'b0, 4);
        exp_end(2, 5);
        start_and_wait("nack5", 4000, -1);
        chk("nack5_fail", 32'(cfg_fail), 1);
        chk("nack5_done", 32'(cfg_done), 0);
        fail_idx = -1;

        // Chip-ID readback mismatch on entry 1.
        bad_id = 1'b1;
        exp_pulse(16'h300A, 8'h56, 1'b1, PWR_WAIT_CYC);
        for (int i = 0; i <= RETRY_MAX; i++) exp_pulse(16'h300B, 8'h40, 1'b1, (i == 0) ? 0 : 4);
        exp_end(2, 1);
        start_and_wait("bad_id", 2000, -1);
        bad_id = 1'b0;

        // Driver never raises busy: each attempt times out after BUSY_TO cycles.
        no_busy = 1'b1;
        exp_pulse(16'h300A, 8'h56, 1'b1, PWR_WAIT_CYC);
        for (int i = 0; i < RETRY_MAX; i++) exp_pulse(16'h300A, 8'h56, 1'b1, BUSY_TO + 5);
        exp_end(2, 0);
        start_and_wait("no_busy", 2000, -1);
        no_busy = 1'b0;

        // Reset while the first transaction is in progress.
        exp_pulse(16'h300A, 8'h56, 1'b1, PWR_WAIT_CYC);
        @(negedge clk_i);
        cfg_start = 1'b1;
        @(negedge clk_i);
        cfg_start = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk_i);
                #1;
                if (i2c_busy) begin
                    seen = 1'b1;
                    break;
                end
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL rst_busy_wait actual=busy_low required=busy_high");
            end
        end
        @(posedge clk_i);
        #1;
        chk("rst_pre_busy", 32'(cfg_busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        repeat (3) @(negedge clk_i);
        chk("midrst_sb_drained", 32'(sb.size()), 0);
        sb.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);

        exp_head();
        exp_pulse(16'h3103, 8'h03, 1'b0, 0);
        exp_pulse(16'h3017, 8'hFF, 1'b0, 0);
        exp_pulse(16'h3018, 8'hFF, 1'b0, 0);
        exp_end(1, REG_NUM - 1);
        start_and_wait("after_rst", 4000, -1);
        chk("after_rst_done", 32'(cfg_done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
